dma_desc_mux_credit: RTL and testbench



---
 rtl/dma_desc_mux_credit.sv | 225 ++++++++++++++++++++++
 tb/tb_dma_desc_mux_credit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_mux_credit.sv
// dma_desc_mux_credit
// Merges PORTS descriptor streams onto a single DMA descriptor channel and
// routes completion status back to the originating port. A port is only
// served while its in-flight count is below MAX_OUTSTANDING and its enable
// is set. The merged descriptor is held in an output register.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_desc_*             per-port descriptor inputs (packed, port 0 in LSBs)
//   m_axis_desc_*             merged descriptor output; ram_sel/tag carry the
//                             port index in their upper bits
//   s_axis_desc_status_*      status from the DMA engine (no backpressure)
//   m_axis_desc_status_*      per-port status, registered, one-cycle strobe
//   port_enable               per-port arbitration enable
//   outstanding_count         per-port in-flight descriptor count
//   status_underflow          pulse: status arrived for a port with count 0
module dma_desc_mux_credit #(
    parameter int PORTS                 = 4,
    parameter int DMA_ADDR_WIDTH        = 64,
    parameter int RAM_ADDR_WIDTH        = 16,
    parameter int S_RAM_SEL_WIDTH       = 2,
    parameter int M_RAM_SEL_WIDTH       = S_RAM_SEL_WIDTH + $clog2(PORTS),
    parameter int LEN_WIDTH             = 16,
    parameter int S_TAG_WIDTH           = 8,
    parameter int M_TAG_WIDTH           = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING       = 16,
    parameter int CNT_WIDTH             = $clog2(MAX_OUTSTANDING + 1),
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [PORTS*DMA_ADDR_WIDTH-1:0]      s_axis_desc_dma_addr,
    input  logic [PORTS*S_RAM_SEL_WIDTH-1:0]     s_axis_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_desc_tag,
    input  logic [PORTS-1:0]                     s_axis_desc_valid,
    output logic [PORTS-1:0]                     s_axis_desc_ready,

    output logic [DMA_ADDR_WIDTH-1:0]            m_axis_desc_dma_addr,
    output logic [M_RAM_SEL_WIDTH-1:0]           m_axis_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]            m_axis_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                 m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]               m_axis_desc_tag,
    output logic                                 m_axis_desc_valid,
    input  logic                                 m_axis_desc_ready,

    input  logic [M_TAG_WIDTH-1:0]               s_axis_desc_status_tag,
    input  logic [3:0]                           s_axis_desc_status_error,
    input  logic                                 s_axis_desc_status_valid,

    output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_desc_status_tag,
    output logic [PORTS*4-1:0]                   m_axis_desc_status_error,
    output logic [PORTS-1:0]                     m_axis_desc_status_valid,

    input  logic [PORTS-1:0]                     port_enable,
    output logic [PORTS*CNT_WIDTH-1:0]           outstanding_count,
    output logic                                 status_underflow
);

    localparam int PW = $clog2(PORTS);
    localparam int SPW = M_TAG_WIDTH - S_TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0]       cnt_q [PORTS];
    logic [CNT_WIDTH-1:0]       cnt_d [PORTS];
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;   // next index to search from
    logic                       m_valid_q, m_valid_d;
    logic [DMA_ADDR_WIDTH-1:0]  m_dma_addr_q, m_dma_addr_d;
    logic [M_RAM_SEL_WIDTH-1:0] m_ram_sel_q, m_ram_sel_d;
    logic [RAM_ADDR_WIDTH-1:0]  m_ram_addr_q, m_ram_addr_d;
    logic [LEN_WIDTH-1:0]       m_len_q, m_len_d;
    logic [M_TAG_WIDTH-1:0]     m_tag_q, m_tag_d;
    logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
    logic [PORTS*4-1:0]         st_err_q, st_err_d;
    logic [PORTS-1:0]           st_valid_q, st_valid_d;
    logic                       underflow_q, underflow_d;

    logic [PORTS-1:0]           eligible;
    logic                       out_free;
    logic                       found;
    logic                       grant;
    logic [PW-1:0]              sel;
    logic [SPW-1:0]             st_port;
    logic                       st_hit;

    // Arbitration
    always_comb begin
        int idx;
        idx = 0;
        eligible = '0;
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = s_axis_desc_valid[i] && port_enable[i] && (cnt_q[i] < MAX_CNT);
        end
        out_free = !m_valid_q || m_axis_desc_ready;
        found = 1'b0;
        sel = '0;
        if (ARB_TYPE_ROUND_ROBIN != 0) begin
            for (int k = 0; k < PORTS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= PORTS) idx = idx - PORTS;
                if (!found && eligible[idx]) begin
                    found = 1'b1;
                    sel = PW'(idx);
                end
            end
        end else if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int k = 0; k < PORTS; k++) begin
                if (!found && eligible[k]) begin
                    found = 1'b1;
                    sel = PW'(k);
                end
            end
        end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                if (!found && eligible[k]) begin
                    found = 1'b1;
                    sel = PW'(k);
                end
            end
        end
        grant = found && out_free && !rst;
        s_axis_desc_ready = '0;
        if (grant) s_axis_desc_ready[sel] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            if (int'(sel) == PORTS - 1) rr_ptr_d = '0;
            else                        rr_ptr_d = sel + 1'b1;
        end
    end

    // Output descriptor register
    always_comb begin
        m_valid_d    = m_valid_q;
        m_dma_addr_d = m_dma_addr_q;
        m_ram_sel_d  = m_ram_sel_q;
        m_ram_addr_d = m_ram_addr_q;
        m_len_d      = m_len_q;
        m_tag_d      = m_tag_q;
        if (grant) begin
            m_valid_d    = 1'b1;
            m_dma_addr_d = s_axis_desc_dma_addr[int'(sel)*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
            m_ram_sel_d  = M_RAM_SEL_WIDTH'({sel, s_axis_desc_ram_sel[int'(sel)*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH]});
            m_ram_addr_d = s_axis_desc_ram_addr[int'(sel)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            m_len_d      = s_axis_desc_len[int'(sel)*LEN_WIDTH +: LEN_WIDTH];
            m_tag_d      = M_TAG_WIDTH'({sel, s_axis_desc_tag[int'(sel)*S_TAG_WIDTH +: S_TAG_WIDTH]});
        end else if (m_axis_desc_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Status routing and in-flight accounting
    always_comb begin
        st_port     = s_axis_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
        st_hit      = s_axis_desc_status_valid && (int'(st_port) < PORTS);
        st_valid_d  = '0;
        st_tag_d    = st_tag_q;
        st_err_d    = st_err_q;
        underflow_d = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (st_hit && int'(st_port) == i) begin
                st_valid_d[i] = 1'b1;
                st_tag_d[i*S_TAG_WIDTH +: S_TAG_WIDTH] = s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
                st_err_d[i*4 +: 4] = s_axis_desc_status_error;
                // A status against an empty counter is reported and not counted;
                // a grant in the same cycle still increments.
                if (cnt_q[i] == '0) underflow_d = 1'b1;
                else                cnt_d[i] = cnt_d[i] - 1'b1;
            end
            if (grant && int'(sel) == i) cnt_d[i] = cnt_d[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
            rr_ptr_q     <= '0;
            m_valid_q    <= 1'b0;
            m_dma_addr_q <= '0;
            m_ram_sel_q  <= '0;
            m_ram_addr_q <= '0;
            m_len_q      <= '0;
            m_tag_q      <= '0;
            st_tag_q     <= '0;
            st_err_q     <= '0;
            st_valid_q   <= '0;
            underflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
            rr_ptr_q     <= rr_ptr_d;
            m_valid_q    <= m_valid_d;
            m_dma_addr_q <= m_dma_addr_d;
            m_ram_sel_q  <= m_ram_sel_d;
            m_ram_addr_q <= m_ram_addr_d;
            m_len_q      <= m_len_d;
            m_tag_q      <= m_tag_d;
            st_tag_q     <= st_tag_d;
            st_err_q     <= st_err_d;
            st_valid_q   <= st_valid_d;
            underflow_q  <= underflow_d;
        end
    end

    always_comb begin
        outstanding_count = '0;
        for (int i = 0; i < PORTS; i++) begin
            outstanding_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign m_axis_desc_valid        = m_valid_q;
    assign m_axis_desc_dma_addr     = m_dma_addr_q;
    assign m_axis_desc_ram_sel      = m_ram_sel_q;
    assign m_axis_desc_ram_addr     = m_ram_addr_q;
    assign m_axis_desc_len          = m_len_q;
    assign m_axis_desc_tag          = m_tag_q;
    assign m_axis_desc_status_tag   = st_tag_q;
    assign m_axis_desc_status_error = st_err_q;
    assign m_axis_desc_status_valid = st_valid_q;
    assign status_underflow         = underflow_q;

endmodule

// File: tb/tb_dma_desc_mux_credit.sv
// Testbench for dma_desc_mux_credit: a round-robin instance and a fixed
// LSB-priority instance share one stimulus stream and are each compared
// against a behavioural model every cycle, plus a few literal expectations.
module tb_dma_desc_mux_credit;

    localparam int P    = 4;
    localparam int DW   = 32;
    localparam int RW   = 16;
    localparam int SW   = 2;
    localparam int MSW  = 4;
    localparam int LW   = 16;
    localparam int STW  = 8;
    localparam int MTW  = 10;
    localparam int MAXO = 2;
    localparam int CW   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [P*DW-1:0]  s_dma_addr;
    logic [P*SW-1:0]  s_ram_sel;
    logic [P*RW-1:0]  s_ram_addr;
    logic [P*LW-1:0]  s_len;
    logic [P*STW-1:0] s_tag;
    logic [P-1:0]     s_valid;
    logic             m_ready;
    logic [MTW-1:0]   st_tag;
    logic [3:0]       st_err;
    logic             st_valid;
    logic [P-1:0]     en;

    logic [P-1:0]     s_ready   [2];
    logic [DW-1:0]    m_dma     [2];
    logic [MSW-1:0]   m_rsel    [2];
    logic [RW-1:0]    m_raddr   [2];
    logic [LW-1:0]    m_len     [2];
    logic [MTW-1:0]   m_tag     [2];
    logic             m_valid   [2];
    logic [P*STW-1:0] o_stag    [2];
    logic [P*4-1:0]   o_serr    [2];
    logic [P-1:0]     o_svalid  [2];
    logic [P*CW-1:0]  o_cnt     [2];
    logic             o_uf      [2];

    always #5 clk = ~clk;

    for (genvar j = 0; j < 2; j++) begin : g_dut
        dma_desc_mux_credit #(
            .PORTS(P), .DMA_ADDR_WIDTH(DW), .RAM_ADDR_WIDTH(RW),
            .S_RAM_SEL_WIDTH(SW), .LEN_WIDTH(LW), .S_TAG_WIDTH(STW),
            .MAX_OUTSTANDING(MAXO),
            .ARB_TYPE_ROUND_ROBIN(j == 0 ? 1 : 0), .ARB_LSB_HIGH_PRIORITY(1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_axis_desc_dma_addr(s_dma_addr), .s_axis_desc_ram_sel(s_ram_sel),
            .s_axis_desc_ram_addr(s_ram_addr), .s_axis_desc_len(s_len),
            .s_axis_desc_tag(s_tag), .s_axis_desc_valid(s_valid),
            .s_axis_desc_ready(s_ready[j]),
            .m_axis_desc_dma_addr(m_dma[j]), .m_axis_desc_ram_sel(m_rsel[j]),
            .m_axis_desc_ram_addr(m_raddr[j]), .m_axis_desc_len(m_len[j]),
            .m_axis_desc_tag(m_tag[j]), .m_axis_desc_valid(m_valid[j]),
            .m_axis_desc_ready(m_ready),
            .s_axis_desc_status_tag(st_tag), .s_axis_desc_status_error(st_err),
            .s_axis_desc_status_valid(st_valid),
            .m_axis_desc_status_tag(o_stag[j]), .m_axis_desc_status_error(o_serr[j]),
            .m_axis_desc_status_valid(o_svalid[j]),
            .port_enable(en), .outstanding_count(o_cnt[j]),
            .status_underflow(o_uf[j])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input int j, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, j, $time, act, exp);
        end
    endtask

    // Behavioural model state, per instance
    int           cnt     [2][P];
    int           rr_next [2];
    bit           e_mv    [2];
    logic [DW-1:0]  e_dma   [2];
    logic [MSW-1:0] e_rsel  [2];
    logic [RW-1:0]  e_raddr [2];
    logic [LW-1:0]  e_len   [2];
    logic [MTW-1:0] e_tag   [2];
    logic [P-1:0]   e_sv    [2];
    logic [STW-1:0] e_stag  [2][P];
    logic [3:0]     e_serr  [2][P];
    bit             e_uf    [2];

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int p = 0; p < P; p++) cnt[j][p] = 0;
            rr_next[j] = 0;
            e_mv[j] = 1'b0;
            e_sv[j] = '0;
            e_uf[j] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 2; j++) begin
                int g, p, sp;
                logic [P-1:0] exp_rdy;
                logic [1:0] gi;
                bit free;
                g = -1;
                free = !e_mv[j] || m_ready;
                for (int k = 0; k < P; k++) begin
                    p = (j == 0) ? (rr_next[j] + k) % P : k;
                    if (g < 0 && s_valid[p] && en[p] && cnt[j][p] < MAXO) g = p;
                end
                if (rst || !free) g = -1;
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;

                chk("s_ready", j, 64'(s_ready[j]), 64'(exp_rdy));
                chk("m_valid", j, 64'(m_valid[j]), 64'(e_mv[j]));
                if (e_mv[j]) begin
                    chk("m_dma_addr", j, 64'(m_dma[j]),   64'(e_dma[j]));
                    chk("m_ram_sel",  j, 64'(m_rsel[j]),  64'(e_rsel[j]));
                    chk("m_ram_addr", j, 64'(m_raddr[j]), 64'(e_raddr[j]));
                    chk("m_len",      j, 64'(m_len[j]),   64'(e_len[j]));
                    chk("m_tag",      j, 64'(m_tag[j]),   64'(e_tag[j]));
                end
                chk("status_valid", j, 64'(o_svalid[j]), 64'(e_sv[j]));
                for (int q = 0; q < P; q++) begin
                    if (e_sv[j][q]) begin
                        chk("status_tag", j, 64'(o_stag[j][q*STW +: STW]), 64'(e_stag[j][q]));
                        chk("status_err", j, 64'(o_serr[j][q*4 +: 4]),     64'(e_serr[j][q]));
                    end
                    chk("count", j, 64'(o_cnt[j][q*CW +: CW]), 64'(cnt[j][q]));
                end
                chk("underflow", j, 64'(o_uf[j]), 64'(e_uf[j]));

                if (!rst) begin
                    e_sv[j] = '0;
                    e_uf[j] = 1'b0;
                    if (st_valid) begin
                        sp = int'(st_tag[MTW-1:STW]);
                        if (sp < P) begin
                            e_sv[j][sp] = 1'b1;
                            e_stag[j][sp] = st_tag[STW-1:0];
                            e_serr[j][sp] = st_err;
                            if (cnt[j][sp] == 0) e_uf[j] = 1'b1;
                            else                 cnt[j][sp]--;
                        end
                    end
                    if (g >= 0) begin
                        gi = g[1:0];
                        cnt[j][g]++;
                        e_mv[j]    = 1'b1;
                        e_dma[j]   = s_dma_addr[g*DW +: DW];
                        e_rsel[j]  = {gi, s_ram_sel[g*SW +: SW]};
                        e_raddr[j] = s_ram_addr[g*RW +: RW];
                        e_len[j]   = s_len[g*LW +: LW];
                        e_tag[j]   = {gi, s_tag[g*STW +: STW]};
                        rr_next[j] = (g + 1) % P;
                    end else if (m_ready) begin
                        e_mv[j] = 1'b0;
                    end
                end
            end
            if (rst) model_reset();
        end
    end

    task automatic rand_fields();
        s_dma_addr = {$urandom, $urandom, $urandom, $urandom};
        s_ram_sel  = 8'($urandom);
        s_ram_addr = {$urandom, $urandom};
        s_len      = {$urandom, $urandom};
        s_tag      = $urandom;
    endtask

    logic [P-1:0] gr0 [5];
    logic [P-1:0] gr1 [5];
    logic [P-1:0] exp0 [5];
    logic [P-1:0] exp1 [5];

    initial begin
        exp0[0] = 4'b0001; exp0[1] = 4'b0010; exp0[2] = 4'b0100; exp0[3] = 4'b1000; exp0[4] = 4'b0001;
        exp1[0] = 4'b0001; exp1[1] = 4'b0001; exp1[2] = 4'b0010; exp1[3] = 4'b0010; exp1[4] = 4'b0100;
        model_reset();
        rst = 1'b1;
        s_valid = 4'hF;
        en = 4'hF;
        m_ready = 1'b1;
        st_tag = '0;
        st_err = '0;
        st_valid = 1'b0;
        rand_fields();
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_m_valid", j, 64'(m_valid[j]), 64'd0);
            chk("rst_s_ready", j, 64'(s_ready[j]), 64'd0);
            chk("rst_count",   j, 64'(o_cnt[j]),   64'd0);
            chk("rst_svalid",  j, 64'(o_svalid[j]), 64'd0);
            chk("rst_uf",      j, 64'(o_uf[j]),    64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // All ports valid, ready held high: grant order per arbitration mode
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            gr0[c] = s_ready[0];
            gr1[c] = s_ready[1];
        end
        @(posedge clk); #1 s_valid = '0;
        for (int c = 0; c < 5; c++) begin
            chk("rr_grant_seq",  0, 64'(gr0[c]), 64'(exp0[c]));
            chk("fix_grant_seq", 1, 64'(gr1[c]), 64'(exp1[c]));
        end
        @(negedge clk);
        chk("cnt_after_grants", 0, 64'(o_cnt[0]), 64'h56);
        chk("cnt_after_grants", 1, 64'(o_cnt[1]), 64'h1A);

        // Status for port 0, tag 0x55
        @(posedge clk); #1 st_tag = {2'd0, 8'h55}; st_err = 4'h3; st_valid = 1'b1;
        @(posedge clk); #1 st_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("st0_valid", j, 64'(o_svalid[j]), 64'h1);
            chk("st0_tag",   j, 64'(o_stag[j][STW-1:0]), 64'h55);
            chk("st0_uf",    j, 64'(o_uf[j]), 64'h0);
        end
        chk("cnt_after_st0", 0, 64'(o_cnt[0]), 64'h55);
        chk("cnt_after_st0", 1, 64'(o_cnt[1]), 64'h19);

        // Status for port 3: instance 1 has nothing outstanding there
        @(posedge clk); #1 st_tag = {2'd3, 8'hA5}; st_err = 4'h9; st_valid = 1'b1;
        @(posedge clk); #1 st_valid = 1'b0;
        @(negedge clk);
        chk("st3_uf",  0, 64'(o_uf[0]), 64'h0);
        chk("st3_uf",  1, 64'(o_uf[1]), 64'h1);
        chk("st3_valid", 1, 64'(o_svalid[1]), 64'h8);
        chk("st3_tag", 1, 64'(o_stag[1][3*STW +: STW]), 64'hA5);
        chk("cnt_after_st3", 0, 64'(o_cnt[0]), 64'h15);
        chk("cnt_after_st3", 1, 64'(o_cnt[1]), 64'h19);
        @(negedge clk);
        chk("st3_uf_pulse", 1, 64'(o_uf[1]), 64'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            s_valid = 4'($urandom);
            for (int p = 0; p < P; p++) en[p] = ($urandom_range(7) != 0);
            m_ready = ($urandom_range(9) < 7);
            rand_fields();
            st_valid = ($urandom_range(3) == 0);
            st_tag = 10'($urandom);
            st_err = 4'($urandom);
            rst = ($urandom_range(999) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = '0;
        st_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
